// File: rtl/clock_time_keeper.sv
// 24-hour BCD time-of-day counter advanced by a tick prescaler, with a set mode for manual hour/minute adjust.
// Registered outputs; seconds update one cycle after the qualifying tick.
module clock_time_keeper #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int TPS_LEN       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_en,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_strobe,
  output logic       day_wrap
);

  localparam logic [TPS_LEN-1:0] PRESC_LAST = TPS_LEN'(TICKS_PER_SEC - 1);

  logic [TPS_LEN-1:0] presc, presc_nxt;
  logic [1:0]         hr_tens_nxt;
  logic [3:0]         hr_ones_nxt;
  logic [2:0]         min_tens_nxt;
  logic [3:0]         min_ones_nxt;
  logic [2:0]         sec_tens_nxt;
  logic [3:0]         sec_ones_nxt;
  logic               sec_strobe_nxt;
  logic               day_wrap_nxt;
  logic               sec_adv, min_adv, hr_adv;

  always_comb begin
    presc_nxt      = presc;
    hr_tens_nxt    = hr_tens;
    hr_ones_nxt    = hr_ones;
    min_tens_nxt   = min_tens;
    min_ones_nxt   = min_ones;
    sec_tens_nxt   = sec_tens;
    sec_ones_nxt   = sec_ones;
    sec_strobe_nxt = 1'b0;
    day_wrap_nxt   = 1'b0;
    sec_adv        = 1'b0;
    min_adv        = 1'b0;
    hr_adv         = 1'b0;

    // Set mode overrides any tick: seconds and prescaler restart from zero.
    if (set_en) begin
      presc_nxt    = '0;
      sec_tens_nxt = '0;
      sec_ones_nxt = '0;
      min_adv      = inc_min;
      hr_adv       = inc_hr;
    end else if (tick) begin
      if (presc == PRESC_LAST) begin
        presc_nxt = '0;
        sec_adv   = 1'b1;
      end else begin
        presc_nxt = presc + TPS_LEN'(1);
      end
    end

    sec_strobe_nxt = sec_adv;
    if (sec_adv) begin
      if (sec_ones == 4'd9) begin
        sec_ones_nxt = 4'd0;
        if (sec_tens == 3'd5) begin
          sec_tens_nxt = 3'd0;
          min_adv      = 1'b1;
        end else begin
          sec_tens_nxt = sec_tens + 3'd1;
        end
      end else begin
        sec_ones_nxt = sec_ones + 4'd1;
      end
    end

    // Minute rollover only carries into hours while running, not while adjusting.
    if (min_adv) begin
      if (min_ones == 4'd9) begin
        min_ones_nxt = 4'd0;
        if (min_tens == 3'd5) begin
          min_tens_nxt = 3'd0;
          if (!set_en) hr_adv = 1'b1;
        end else begin
          min_tens_nxt = min_tens + 3'd1;
        end
      end else begin
        min_ones_nxt = min_ones + 4'd1;
      end
    end

    if (hr_adv) begin
      if (hr_tens == 2'd2 && hr_ones == 4'd3) begin
        hr_tens_nxt  = 2'd0;
        hr_ones_nxt  = 4'd0;
        day_wrap_nxt = !set_en;
      end else if (hr_ones == 4'd9) begin
        hr_ones_nxt = 4'd0;
        hr_tens_nxt = hr_tens + 2'd1;
      end else begin
        hr_ones_nxt = hr_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      hr_tens    <= '0;
      hr_ones    <= '0;
      min_tens   <= '0;
      min_ones   <= '0;
      sec_tens   <= '0;
      sec_ones   <= '0;
      sec_strobe <= 1'b0;
      day_wrap   <= 1'b0;
    end else begin
      presc      <= presc_nxt;
      hr_tens    <= hr_tens_nxt;
      hr_ones    <= hr_ones_nxt;
      min_tens   <= min_tens_nxt;
      min_ones   <= min_ones_nxt;
      sec_tens   <= sec_tens_nxt;
      sec_ones   <= sec_ones_nxt;
      sec_strobe <= sec_strobe_nxt;
      day_wrap   <= day_wrap_nxt;
    end
  end

endmodule

// File: tb/tb_clock_time_keeper.sv
// Bench for clock_time_keeper: directed scenarios plus random stimulus, checked every cycle
// against a seconds-of-day reference model.
module tb_clock_time_keeper;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, set_en = 1'b0, inc_hr = 1'b0, inc_min = 1'b0;
  logic [1:0] hr_tens;
  logic [3:0] hr_ones;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       sec_strobe, day_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int m_secs   = 0;
  int m_cnt    = 0;
  bit e_str    = 1'b0;
  bit e_wrap   = 1'b0;
  int n_str    = 0;
  int n_wrap   = 0;

  clock_time_keeper #(.TICKS_PER_SEC(TPS), .TPS_LEN(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .set_en(set_en), .inc_hr(inc_hr), .inc_min(inc_min),
    .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .sec_strobe(sec_strobe), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [23:0] obs_time();
    return {2'b0, hr_tens, hr_ones, 1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};
  endfunction

  task automatic model_step(input bit t, input bit s, input bit ih, input bit im);
    int h, m;
    e_str  = 1'b0;
    e_wrap = 1'b0;
    if (s) begin
      h = m_secs / 3600;
      m = (m_secs / 60) % 60;
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      m_secs = h * 3600 + m * 60;
      m_cnt  = 0;
    end else if (t) begin
      m_cnt++;
      if (m_cnt == TPS) begin
        m_cnt  = 0;
        m_secs = (m_secs + 1) % 86400;
        e_str  = 1'b1;
        e_wrap = (m_secs == 0);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".time"}, 32'(obs_time()), 32'(bcd(m_secs)));
    check({tag, ".pulse"}, 32'({sec_strobe, day_wrap}), 32'({e_str, e_wrap}));
  endtask

  task automatic cyc(input bit t, input bit s, input bit ih, input bit im);
    tick = t; set_en = s; inc_hr = ih; inc_min = im;
    @(posedge clk);
    #1;
    model_step(t, s, ih, im);
    if (sec_strobe) n_str++;
    if (day_wrap) n_wrap++;
    check_all("cyc");
  endtask

  task automatic set_hm(input int h, input int mm);
    cyc(0, 1, 0, 0);
    while (m_secs / 3600 != h) cyc(0, 1, 1, 0);
    while ((m_secs / 60) % 60 != mm) cyc(0, 1, 0, 1);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  int str0, wrap0;
  bit mode;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset.time", 32'(obs_time()), 32'h0);
    check("reset.pulse", 32'({sec_strobe, day_wrap}), 32'h0);
    rst = 1'b0;

    // Four spaced single-cycle ticks -> exactly one second.
    str0 = n_str;
    for (int i = 0; i < TPS; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    check("first_sec.time", 32'(obs_time()), 32'h000001);
    check("first_sec.strobes", 32'(n_str - str0), 32'd1);

    // Preset 23:59:59 then roll over the day.
    set_hm(23, 59);
    cyc(0, 0, 0, 0);
    run_ticks(59 * TPS);
    check("pre_wrap.time", 32'(obs_time()), 32'h235959);
    wrap0 = n_wrap;
    str0  = n_str;
    run_ticks(TPS);
    check("wrap.time", 32'(obs_time()), 32'h000000);
    check("wrap.count", 32'(n_wrap - wrap0), 32'd1);
    check("wrap.strobes", 32'(n_str - str0), 32'd1);

    // Set mode at 12:34:56, minute and hour rollovers without carry.
    set_hm(12, 34);
    cyc(0, 0, 0, 0);
    run_ticks(56 * TPS);
    check("t123456.time", 32'(obs_time()), 32'h123456);
    cyc(0, 1, 0, 0);
    check("set_clr_sec.time", 32'(obs_time()), 32'h123400);
    while ((m_secs / 60) % 60 != 59) cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    check("min_roll.time", 32'(obs_time()), 32'h120000);
    wrap0 = n_wrap;
    while (m_secs / 3600 != 23) cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    check("hr_roll.time", 32'(obs_time()), 32'h000000);
    check("hr_roll.nowrap", 32'(n_wrap - wrap0), 32'd0);

    // Set and qualifying tick together; then simultaneous inc_hr/inc_min.
    cyc(0, 0, 0, 0);
    run_ticks(TPS - 1);
    cyc(1, 1, 0, 0);
    check("set_vs_tick.time", 32'(obs_time()), 32'h000000);
    set_hm(5, 9);
    cyc(0, 1, 1, 1);
    check("both_inc.time", 32'(obs_time()), 32'h061000);
    str0 = n_str;
    run_ticks(TPS - 1);
    check("resume.nostrobe", 32'(n_str - str0), 32'd0);
    run_ticks(1);
    check("resume.time", 32'(obs_time()), 32'h061001);

    // Asynchronous reset at 07:08:09 with prescaler at 2.
    set_hm(7, 8);
    cyc(0, 0, 0, 0);
    run_ticks(9 * TPS + 2);
    check("pre_rst.time", 32'(obs_time()), 32'h070809);
    #2 rst = 1'b1;
    #1;
    check("async_rst.time", 32'(obs_time()), 32'h0);
    check("async_rst.pulse", 32'({sec_strobe, day_wrap}), 32'h0);
    #1 rst = 1'b0;
    m_secs = 0; m_cnt = 0;
    run_ticks(TPS - 1);
    check("post_rst.partial", 32'(obs_time()), 32'h000000);
    run_ticks(1);
    check("post_rst.time", 32'(obs_time()), 32'h000001);

    // Adjust pulses ignored outside set mode; held tick counts every cycle.
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    check("ignored_inc.time", 32'(obs_time()), 32'h000001);
    str0 = n_str;
    run_ticks(2 * TPS);
    check("held_tick.strobes", 32'(n_str - str0), 32'd2);
    check("held_tick.time", 32'(obs_time()), 32'h000003);

    // Random traffic with occasional set-mode excursions.
    mode = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) mode = !mode;
      cyc(bit'($urandom_range(0, 9) < 7), mode,
          bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_keeper.md
CLOCK_TIME_KEEPER -- requirements
Module: clock_time_keeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000: number of input tick pulses per second; legal range 1..2^TPS_LEN.
REQ-002 Parameter TPS_LEN, default 10: width of the tick prescaler.
REQ-003 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port tick, input, 1: single-cycle pulse from the upstream tick generator; any pulse width above one cycle counts once per high cycle.
REQ-006 Port set_en, input, 1: set mode; high freezes timekeeping and enables manual adjust.
REQ-007 Port inc_hr, input, 1: single-cycle pulse; advances hours by one in set mode.
REQ-008 Port inc_min, input, 1: single-cycle pulse; advances minutes by one in set mode.
REQ-009 Port hr_tens, output, 2: hours tens digit, BCD, 0..2.
REQ-010 Port hr_ones, output, 4: hours ones digit, BCD, 0..9.
REQ-011 Port min_tens, output, 3: minutes tens digit, BCD, 0..5.
REQ-012 Port min_ones, output, 4: minutes ones digit, BCD, 0..9.
REQ-013 Port sec_tens, output, 3: seconds tens digit, BCD, 0..5.
REQ-014 Port sec_ones, output, 4: seconds ones digit, BCD, 0..9.
REQ-015 Port sec_strobe, output, 1: one-cycle pulse each time seconds advance.
REQ-016 Port day_wrap, output, 1: one-cycle pulse when time rolls 23:59:59 -> 00:00:00.

Function
REQ-017 All outputs SHALL be driven directly from registers; no combinational path from any input to any output.
REQ-018 Prescaler SHALL count tick-high cycles from 0 to TICKS_PER_SEC-1; the tick that arrives at count TICKS_PER_SEC-1 wraps the prescaler to 0 and advances seconds.
REQ-019 A seconds advance SHALL be visible on the digit outputs in the cycle after the qualifying tick cycle; sec_strobe SHALL be high in that same cycle only.
REQ-020 Digit cascade: sec_ones 9 -> 0 carries into sec_tens; sec_tens 5 with carry -> 0 carries into min_ones; minutes identical; min carry into hours.
REQ-021 Hours SHALL count 00..23; 23 plus carry -> 00, and day_wrap SHALL pulse in the same cycle the 00:00:00 value appears.
REQ-022 Digit outputs SHALL never hold a non-BCD or out-of-range value (e.g. 24:xx, x6:xx).
REQ-023 While set_en is high: prescaler held at 0, seconds held at 00, tick ignored, sec_strobe and day_wrap held low.
REQ-024 In set mode, inc_min SHALL advance minutes mod 60 with no carry into hours; inc_hr SHALL advance hours mod 24 with no day_wrap; result visible next cycle.
REQ-025 inc_min and inc_hr asserted in the same cycle SHALL both take effect in that cycle.
REQ-026 inc_min and inc_hr SHALL be ignored while set_en is low.
REQ-027 set_en and a qualifying tick in the same cycle: set mode wins; no seconds advance.
REQ-028 On set_en falling, counting SHALL resume from prescaler 0 and seconds 00; the first seconds advance follows TICKS_PER_SEC further ticks.
REQ-029 TICKS_PER_SEC = 1: every tick advances seconds.

Reset
REQ-030 rst high SHALL asynchronously force all digits to 0 (00:00:00), prescaler to 0, sec_strobe and day_wrap to 0.
REQ-031 rst asserted mid-count or mid-set SHALL discard all state; after release the first seconds advance requires a full TICKS_PER_SEC ticks.
REQ-032 The first clock edge after rst release SHALL act on inputs normally.

Verification
REQ-033 TICKS_PER_SEC=4: 4 single-cycle ticks after reset -> 00:00:01 and one sec_strobe in the cycle after the 4th tick; none after ticks 1-3.
REQ-034 Preset 23:59:59 via set mode (inc_hr x23, inc_min x59, then 59 s of ticks), one more second -> 00:00:00, day_wrap and sec_strobe both pulse once.
REQ-035 set_en high at 12:34:56: seconds -> 00 next cycle; inc_min at min 59 -> 12:00:00 (hours unchanged); inc_hr at 23 -> 00, no day_wrap.
REQ-036 set_en and tick high together at prescaler 3 (TICKS_PER_SEC=4) -> no advance, prescaler 0; inc_hr and inc_min together at 05:09 -> 06:10.
REQ-037 rst pulsed asynchronously (between clk edges) at 07:08:09 with prescaler 2 -> outputs 00:00:00 immediately; 4 ticks after release -> 00:00:01.
REQ-038 inc_hr/inc_min pulses with set_en low -> no digit change; tick held high 8 cycles (TICKS_PER_SEC=4) -> seconds advance twice.
